// File: rtl/rca_pkg.sv
// Shared sizing helpers for the pipelined ripple-carry adder.
package rca_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    // Bits added per pipeline stage.
    function automatic int rca_chunk(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 0;
    endfunction

    // A legal configuration splits the operands into equal, non-empty chunks.
    function automatic bit rca_cfg_ok(input int width, input int stages);
        return (stages > 0) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; chained to form each stage's ripple.
module full_adder
    import rca_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_stage.sv
// One pipeline stage: ripples CHUNK bits at offset IDX*CHUNK and registers
// the partially summed word, the remaining B operand, carry and overflow.
// The word register carries A in its unconsumed upper bits and the finished
// sum in its lower bits, so a single vector walks down the pipe.
module rca_stage
    import rca_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    input  logic             nxt_load,
    output logic             load,
    output logic             vld_q,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] data_q,
    output logic [WIDTH-1:0] b_q,
    output logic             c_q,
    output logic             ovf_q
);

    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] s;
    logic [WIDTH-1:0] data_nxt;

    assign c[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a    (data_in[LO+i]),
            .b    (b_in[LO+i]),
            .cin  (c[i]),
            .sum  (s[i]),
            .cout (c[i+1])
        );
    end

    // Replace this stage's A bits with their sum bits.
    always_comb begin
        data_nxt = data_in;
        data_nxt[LO +: CHUNK] = s;
    end

    // Empty, or the current occupant moves on this cycle.
    assign load = !vld_q || nxt_load;

    // Valid bit follows upstream whenever the stage can load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       vld_q <= 1'b0;
        else if (load) vld_q <= vld_in;
    end

    // Payload only captured for real beats; bubbles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load && vld_in) begin
            data_q <= data_nxt;
            b_q    <= b_in;
            c_q    <= c[CHUNK];
            ovf_q  <= c[CHUNK-1] ^ c[CHUNK];
        end
    end

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor, STAGES chunks of WIDTH/STAGES
// bits, valid/ready on both sides with bubble collapse.
module pipelined_rca_adder
    import rca_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int CHUNK = rca_chunk(WIDTH, STAGES);

    if (!rca_cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_rca_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end

    // Index k is the input side of stage k; index STAGES is the output.
    logic [STAGES:0]            vld;
    logic [STAGES:0]            load;
    logic [STAGES:0][WIDTH-1:0] data;
    logic [STAGES:0][WIDTH-1:0] bop;
    logic [STAGES:0]            cy;
    logic [STAGES:0]            ovf;

    // Subtract is A + ~B + 1; the inversion happens once at entry.
    assign vld[0]       = in_valid;
    assign data[0]      = in_a;
    assign bop[0]       = in_sub ? ~in_b : in_b;
    assign cy[0]        = in_sub | in_cin;
    assign ovf[0]       = 1'b0;
    assign load[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .vld_in   (vld[k]),
            .nxt_load (load[k+1]),
            .load     (load[k]),
            .vld_q    (vld[k+1]),
            .data_in  (data[k]),
            .b_in     (bop[k]),
            .c_in     (cy[k]),
            .data_q   (data[k+1]),
            .b_q      (bop[k+1]),
            .c_q      (cy[k+1]),
            .ovf_q    (ovf[k+1])
        );
    end

    assign in_ready  = load[0];
    assign out_valid = vld[STAGES];
    assign out_sum   = data[STAGES];
    assign out_cout  = cy[STAGES];
    assign out_ovf   = ovf[STAGES];

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Scoreboard bench for pipelined_rca_adder (16-bit, 4 stages) plus two
// auxiliary instances (1 and 16 stages) exercised for reset and latency.
module tb_pipelined_rca_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_cin, in_sub;
    logic [15:0] in_a, in_b;
    logic        out_valid, out_ready, out_cout, out_ovf;
    logic [15:0] out_sum;

    // Auxiliary instances: [0] STAGES=1, [1] STAGES=16.
    logic        xiv [2];
    logic        xir [2];
    logic        xov [2];
    logic        xrdy[2];
    logic        xco [2];
    logic        xovf[2];
    logic [15:0] xa  [2];
    logic [15:0] xb  [2];
    logic [15:0] xsum[2];
    logic        xcin, xsub;

    int tests = 0;
    int fails = 0;
    int popped = 0;

    res_t expq[$];
    logic        hold_v = 1'b0;
    logic [15:0] hold_sum;
    logic        hold_cout, hold_ovf;

    pipelined_rca_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );

    pipelined_rca_adder #(.WIDTH(16), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .in_valid(xiv[0]), .in_ready(xir[0]), .in_a(xa[0]), .in_b(xb[0]),
        .in_cin(xcin), .in_sub(xsub),
        .out_valid(xov[0]), .out_ready(xrdy[0]), .out_sum(xsum[0]),
        .out_cout(xco[0]), .out_ovf(xovf[0])
    );

    pipelined_rca_adder #(.WIDTH(16), .STAGES(16)) dut_s16 (
        .clk(clk), .rst(rst),
        .in_valid(xiv[1]), .in_ready(xir[1]), .in_a(xa[1]), .in_b(xb[1]),
        .in_cin(xcin), .in_sub(xsub),
        .out_valid(xov[1]), .out_ready(xrdy[1]), .out_sum(xsum[1]),
        .out_cout(xco[1]), .out_ovf(xovf[1])
    );

    // Reference: plain integer arithmetic and sign-rule overflow.
    function automatic res_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin, input logic sub);
        res_t r;
        logic [16:0] t;
        if (!sub) begin
            t      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            r.sum  = t[15:0];
            r.cout = t[16];
            r.ovf  = (a[15] == b[15]) && (r.sum[15] != a[15]);
        end else begin
            r.sum  = a - b;
            r.cout = (a >= b);
            r.ovf  = (a[15] != b[15]) && (r.sum[15] != a[15]);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: push on input handshake, pop/compare on output handshake,
    // and hold-stability while the consumer stalls.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_stable", {out_valid, out_sum, out_cout, out_ovf},
                      {1'b1, hold_sum, hold_cout, hold_ovf});
                hold_v = 1'b0;
            end
            if (in_valid && in_ready)
                expq.push_back(ref_model(in_a, in_b, in_cin, in_sub));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("spurious_output", {out_sum, out_cout, out_ovf}, 32'hDEAD);
                end else begin
                    res_t e;
                    e = expq.pop_front();
                    check("result", {out_sum, out_cout, out_ovf}, {e.sum, e.cout, e.ovf});
                end
                popped++;
            end else if (out_valid) begin
                hold_v    = 1'b1;
                hold_sum  = out_sum;
                hold_cout = out_cout;
                hold_ovf  = out_ovf;
            end
        end
    end

    task automatic set_in(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic v);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipe; measures latency and checks constants.
    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic sub, input logic [15:0] es, input logic ec,
                            input logic eo);
        int lat;
        out_ready = 1'b1;
        set_in(a, b, cin, sub, 1'b1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, 4);
        check("dir_sum", out_sum, es);
        check("dir_cout", out_cout, ec);
        check("dir_ovf", out_ovf, eo);
        tick();
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int acc, p0, cyc, nv;
        logic pend;
        logic [15:0] pa, pb;
        logic pc, ps;
        int lat_x[2];

        rst = 1'b1;
        set_in(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        xcin = 1'b0; xsub = 1'b0;
        for (int i = 0; i < 2; i++) begin
            xiv[i] = 1'b0; xa[i] = '0; xb[i] = '0; xrdy[i] = 1'b1;
        end

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_flags", {out_cout, out_ovf}, 0);
        check("rst_aux_valid", {xov[0], xov[1]}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", in_ready, 1);

        // Directed corner cases
        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // 20 back-to-back beats at full throughput
        p0 = popped;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_in(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            #1;
            check("b2b_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check("b2b_count", popped - p0, 20);
        check("b2b_drained", out_valid, 0);

        // Back-pressure: fill the pipe, then release
        out_ready = 1'b0;
        acc = 0;
        pend = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!pend) begin
                pa = 16'($urandom); pb = 16'($urandom); pc = 1'($urandom); ps = 1'($urandom);
                pend = 1'b1;
            end
            set_in(pa, pb, pc, ps, 1'b1);
            #1;
            if (in_ready) begin acc++; pend = 1'b0; end
            tick();
        end
        check("bp_accepted", acc, 4);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (!pend) begin
                pa = 16'($urandom); pb = 16'($urandom); pc = 1'($urandom); ps = 1'($urandom);
                pend = 1'b1;
            end
            set_in(pa, pb, pc, ps, 1'b1);
            #1;
            if (in_ready) pend = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        check("bp_queue_empty", expq.size(), 0);

        // Random valid/ready toggling, 1000 accepted beats
        acc = 0;
        cyc = 0;
        pend = 1'b0;
        while (acc < 1000 && cyc < 20000) begin
            if (!pend && ($urandom_range(3) != 0)) begin
                case ($urandom_range(5))
                    0:       pa = 16'hFFFF;
                    1:       pa = 16'h8000;
                    default: pa = 16'($urandom);
                endcase
                pb = ($urandom_range(5) == 0) ? 16'h7FFF : 16'($urandom);
                pc = 1'($urandom); ps = 1'($urandom);
                pend = 1'b1;
            end
            set_in(pa, pb, pc, ps, pend);
            out_ready = ($urandom_range(2) != 0);
            #1;
            if (in_valid && in_ready) begin acc++; pend = 1'b0; end
            tick();
            cyc++;
        end
        check("rand_accepted", acc, 1000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (expq.size() != 0 && cyc < 100) begin tick(); cyc++; end
        check("rand_queue_empty", expq.size(), 0);

        // Reset with beats in flight, all three depths
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) xrdy[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
            for (int j = 0; j < 2; j++) begin
                xiv[j] = 1'b1; xa[j] = 16'($urandom); xb[j] = 16'($urandom);
            end
            tick();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 2; j++) xiv[j] = 1'b0;
        tick();
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_s1_valid", xov[0], 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_aux_valid", {xov[0], xov[1]}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int j = 0; j < 2; j++) xrdy[j] = 1'b1;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || xov[0] || xov[1]) nv++;
            tick();
        end
        check("no_stale_after_rst", nv, 0);
        directed(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Post-reset latency on the 1- and 16-stage instances
        for (int j = 0; j < 2; j++) begin
            xiv[j] = 1'b1; xa[j] = 16'hA5A5; xb[j] = 16'h5A5B;
        end
        tick();
        for (int j = 0; j < 2; j++) begin xiv[j] = 1'b0; lat_x[j] = 0; end
        for (int c = 1; c <= 40; c++) begin
            for (int j = 0; j < 2; j++) begin
                if (xov[j] && lat_x[j] == 0) begin
                    lat_x[j] = c;
                    check("aux_sum", {xsum[j], xco[j], xovf[j]}, {16'h0000, 1'b1, 1'b0});
                end
            end
            if (lat_x[0] != 0 && lat_x[1] != 0) break;
            tick();
        end
        check("s1_latency", lat_x[0], 1);
        check("s16_latency", lat_x[1], 16);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
